// File: rtl/branch_resolve_unit.sv
// Branch resolution for the EX stage: evaluates the RV32I branch condition, raises a redirect
// to fetch for taken branches, then squashes younger instructions for a fixed number of cycles.
module branch_resolve_unit #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic [2:0]  br_funct3,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_imm,
    output logic        compare_signed,
    input  logic        a_lt_b,
    input  logic        a_eq_b,
    output logic        redirect_valid,
    input  logic        redirect_ready,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        err_pulse,
    output logic [15:0] taken_cnt
);

    typedef enum logic [1:0] {StIdle, StRedirect, StFlush} state_e;

    state_e      state_q, state_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [15:0] taken_cnt_q, taken_cnt_d;
    logic [3:0]  flush_cnt_q, flush_cnt_d;
    logic        err_q, err_d;
    logic [31:0] target;
    logic        accept, legal, cond_met, taken, misaligned;

    assign compare_signed = (br_funct3 == 3'b100) || (br_funct3 == 3'b101);

    always_comb begin
        legal    = 1'b1;
        cond_met = 1'b0;
        unique case (br_funct3)
            3'b000:         cond_met = a_eq_b;
            3'b001:         cond_met = !a_eq_b;
            3'b100, 3'b110: cond_met = a_lt_b;
            3'b101, 3'b111: cond_met = !a_lt_b;
            default:        legal    = 1'b0;
        endcase
    end

    assign target     = br_pc + br_imm;
    assign accept     = br_valid && (state_q == StIdle);
    assign taken      = legal && cond_met;
    assign misaligned = (target[1:0] != 2'b00);

    always_comb begin
        state_d        = state_q;
        redirect_pc_d  = redirect_pc_q;
        taken_cnt_d    = taken_cnt_q;
        flush_cnt_d    = flush_cnt_q;
        br_ready       = 1'b0;
        redirect_valid = 1'b0;
        flush          = 1'b0;
        // Misaligned taken branches are reported but never redirect or count.
        err_d          = accept && (!legal || (taken && misaligned));
        unique case (state_q)
            StIdle: begin
                br_ready = 1'b1;
                if (accept && taken && !misaligned) begin
                    redirect_pc_d = target;
                    state_d       = StRedirect;
                    if (taken_cnt_q != 16'hFFFF) begin
                        taken_cnt_d = taken_cnt_q + 16'd1;
                    end
                end
            end
            StRedirect: begin
                redirect_valid = 1'b1;
                flush          = 1'b1;
                if (redirect_ready) begin
                    state_d     = StFlush;
                    flush_cnt_d = 4'(FLUSH_CYCLES);
                end
            end
            StFlush: begin
                flush       = 1'b1;
                flush_cnt_d = flush_cnt_q - 4'd1;
                if (flush_cnt_q <= 4'd1) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            redirect_pc_q <= 32'h0;
            taken_cnt_q   <= 16'h0;
            flush_cnt_q   <= 4'h0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
            taken_cnt_q   <= taken_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            err_q         <= err_d;
        end
    end

    assign redirect_pc = redirect_pc_q;
    assign taken_cnt   = taken_cnt_q;
    assign err_pulse   = err_q;

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter: FLUSH_CYCLES, 2, number of flush cycles after redirect handshake (legal 1..15).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: br_valid  input  1  branch instruction present in EX.
REQ-005 SHALL have port: br_ready  output  1  unit can accept a branch.
REQ-006 SHALL have port: br_funct3  input  3  RV32I branch funct3.
REQ-007 SHALL have port: br_pc  input  32  PC of the branch.
REQ-008 SHALL have port: br_imm  input  32  sign-extended B-type immediate.
REQ-009 SHALL have port: compare_signed  output  1  to compare unit; 1 = signed compare, 0 = unsigned.
REQ-010 SHALL have port: a_lt_b  input  1  compare unit less-than result.
REQ-011 SHALL have port: a_eq_b  input  1  compare unit equal result.
REQ-012 SHALL have port: redirect_valid  output  1  redirect request to fetch.
REQ-013 SHALL have port: redirect_ready  input  1  fetch accepts redirect.
REQ-014 SHALL have port: redirect_pc  output  32  branch target.
REQ-015 SHALL have port: flush  output  1  squash younger IF/ID instructions.
REQ-016 SHALL have port: err_pulse  output  1  one-cycle pulse: illegal funct3 or misaligned target.
REQ-017 SHALL have port: taken_cnt  output  16  saturating count of taken branches.

Function
REQ-018 compare_signed SHALL be combinational from br_funct3: 1 for 100/101 (BLT/BGE), 0 otherwise.
REQ-019 Condition SHALL be: 000 eq; 001 !eq; 100/110 lt; 101/111 !lt; 010/011 illegal (not taken).
REQ-020 Accept SHALL occur on cycle where br_valid & br_ready; br_ready SHALL be 1 only in IDLE.
REQ-021 Target SHALL be br_pc + br_imm modulo 2^32 (wrap-around, no carry out).
REQ-022 FSM states SHALL be IDLE, REDIRECT, FLUSH.
REQ-023 IDLE, accept, taken, target[1:0]==00 -> latch target into redirect_pc, go REDIRECT, increment taken_cnt.
REQ-024 IDLE, accept, not taken -> stay IDLE, no outputs change except err_pulse per REQ-027.
REQ-025 REDIRECT: redirect_valid=1, flush=1; redirect_pc SHALL hold stable until redirect_ready; on redirect_ready go FLUSH, load counter FLUSH_CYCLES.
REQ-026 FLUSH: flush=1, redirect_valid=0, counter decrements each cycle; at 1 -> IDLE next edge, so flush lasts exactly FLUSH_CYCLES cycles after handshake cycle.
REQ-027 err_pulse SHALL assert the cycle after accept with illegal funct3 or taken with target[1:0]!=00; misaligned taken branch SHALL NOT redirect and SHALL NOT count.
REQ-028 Latency: taken branch accepted at cycle N -> redirect_valid=1 at N+1; redirect_ready already high at N+1 -> FLUSH at N+2.
REQ-029 taken_cnt SHALL saturate at 0xFFFF, never wrap.
REQ-030 br_valid while not IDLE SHALL be ignored (not accepted, no counter/err effect).

Reset
REQ-031 rst_n low SHALL immediately force IDLE, redirect_valid=0, redirect_pc=0, flush=0, err_pulse=0, taken_cnt=0, flush counter=0, independent of clk.
REQ-032 Reset asserted mid-REDIRECT or mid-FLUSH SHALL abandon the operation; after release the unit SHALL be in IDLE with br_ready=1.

Verification
REQ-033 BEQ, a_eq_b=1, pc=0x100, imm=0x20, redirect_ready=1 -> redirect_valid next cycle with redirect_pc=0x120, then flush 1+2 cycles total, taken_cnt=1.
REQ-034 BLTU funct3=110, a_lt_b=0 -> compare_signed=0, no redirect, flush=0, br_ready stays 1.
REQ-035 BGE taken, pc=0xFFFFFFF0, imm=0x20, redirect_ready low 3 cycles -> redirect_pc=0x00000010 stable all 3 cycles, FLUSH entered only after ready.
REQ-036 funct3=010 and BNE taken with imm=0x6 -> err_pulse one cycle each, no redirect, taken_cnt unchanged.
REQ-037 rst_n low during FLUSH cycle 1 -> flush=0 immediately; after release br_ready=1, taken_cnt=0.
REQ-038 taken_cnt preloaded to 0xFFFF by 65535 taken branches, one more taken -> stays 0xFFFF.
